// File: rtl/bp_cfg_link_responder.sv
// Tile-side configuration link responder: one outstanding read/write command,
// one registered response, runtime config registers for a single tile.
module bp_cfg_link_responder #(
    parameter int   cfg_addr_width_p = 16,
    parameter int   cfg_data_width_p = 64,
    parameter int   core_id_width_p  = 4,
    parameter int   cce_id_width_p   = 4,
    parameter int   cfg_id_p         = 3,
    parameter logic reset_freeze_p   = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        cmd_v_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_w_i,
    input  logic [cfg_addr_width_p-1:0] cmd_addr_i,
    input  logic [cfg_data_width_p-1:0] cmd_data_i,
    output logic                        resp_v_o,
    input  logic                        resp_yumi_i,
    output logic [cfg_data_width_p-1:0] resp_data_o,
    output logic                        resp_err_o,
    output logic                        freeze_o,
    output logic [core_id_width_p-1:0]  core_id_o,
    output logic [cce_id_width_p-1:0]   cce_id_o,
    output logic [1:0]                  icache_mode_o,
    output logic [1:0]                  dcache_mode_o,
    output logic                        cce_mode_o
);

    typedef enum logic {
        E_IDLE = 1'b0,
        E_RESP = 1'b1
    } state_e;

    state_e                      state_q;
    logic                        cmd_ready_q;
    logic                        resp_v_q;
    logic                        resp_err_q;
    logic [cfg_data_width_p-1:0] resp_data_q;

    logic                        freeze_q;
    logic [core_id_width_p-1:0]  core_id_q;
    logic [cce_id_width_p-1:0]   cce_id_q;
    logic [1:0]                  icache_mode_q;
    logic [1:0]                  dcache_mode_q;
    logic                        cce_mode_q;
    logic [cfg_data_width_p-1:0] scratch_q;

    logic                        addr_ok;
    logic                        accept;
    logic [2:0]                  idx;
    logic [cfg_data_width_p-1:0] rdata;
    logic                        err_d;
    logic [cfg_data_width_p-1:0] resp_data_d;

    // Decode the presented command; only consumed on the accepting edge.
    always_comb begin
        idx     = cmd_addr_i[2:0];
        addr_ok = (cmd_addr_i[cfg_addr_width_p-1:3] == '0);
        accept  = cmd_v_i && cmd_ready_q;
        rdata   = '0;
        case (idx)
            3'd0: rdata = cfg_data_width_p'(freeze_q);
            3'd1: rdata = cfg_data_width_p'(core_id_q);
            3'd2: rdata = cfg_data_width_p'(cce_id_q);
            3'd3: rdata = cfg_data_width_p'(icache_mode_q);
            3'd4: rdata = cfg_data_width_p'(dcache_mode_q);
            3'd5: rdata = cfg_data_width_p'(cce_mode_q);
            3'd6: rdata = cfg_data_width_p'(cfg_id_p);
            3'd7: rdata = scratch_q;
        endcase
        err_d = !addr_ok
             || (cmd_w_i && (idx == 3'd6))
             || (cmd_w_i && ((idx == 3'd3) || (idx == 3'd4)) && (cmd_data_i[1:0] == 2'b11));
        resp_data_d = (cmd_w_i || err_d) ? '0 : rdata;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= E_IDLE;
            cmd_ready_q   <= 1'b0;
            resp_v_q      <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_data_q   <= '0;
            freeze_q      <= reset_freeze_p;
            core_id_q     <= '0;
            cce_id_q      <= '0;
            icache_mode_q <= '0;
            dcache_mode_q <= '0;
            cce_mode_q    <= 1'b0;
            scratch_q     <= '0;
        end else begin
            case (state_q)
                E_IDLE: begin
                    if (accept) begin
                        state_q     <= E_RESP;
                        cmd_ready_q <= 1'b0;
                        resp_v_q    <= 1'b1;
                        resp_err_q  <= err_d;
                        resp_data_q <= resp_data_d;
                        if (cmd_w_i && !err_d) begin
                            case (idx)
                                3'd0: freeze_q      <= cmd_data_i[0];
                                3'd1: core_id_q     <= cmd_data_i[core_id_width_p-1:0];
                                3'd2: cce_id_q      <= cmd_data_i[cce_id_width_p-1:0];
                                3'd3: icache_mode_q <= cmd_data_i[1:0];
                                3'd4: dcache_mode_q <= cmd_data_i[1:0];
                                3'd5: cce_mode_q    <= cmd_data_i[0];
                                3'd7: scratch_q     <= cmd_data_i;
                                default: ;
                            endcase
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                E_RESP: begin
                    // Ready stays low through the yumi cycle, so the earliest new accept is one cycle later.
                    if (resp_yumi_i) begin
                        state_q     <= E_IDLE;
                        cmd_ready_q <= 1'b1;
                        resp_v_q    <= 1'b0;
                        resp_err_q  <= 1'b0;
                        resp_data_q <= '0;
                    end
                end
                default: state_q <= E_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign resp_v_o      = resp_v_q;
    assign resp_err_o    = resp_err_q;
    assign resp_data_o   = resp_data_q;
    assign freeze_o      = freeze_q;
    assign core_id_o     = core_id_q;
    assign cce_id_o      = cce_id_q;
    assign icache_mode_o = icache_mode_q;
    assign dcache_mode_o = dcache_mode_q;
    assign cce_mode_o    = cce_mode_q;

endmodule
